rsa_frame_sequencer: RTL and testbench
======================================

# rsa_frame_sequencer

Upstream feeder and downstream collector for the RSA datapath core in the RFID tag pipeline. Accepts a frame of FrameLen plaintext words (e.g. a 96-bit EPC as 12 bytes) over a valid/ready stream, presents each word with the frame's key and modulus to the datapath, and holds the load enable for the whole computation. It waits for the core's completion flag, captures the result and emits the ciphertext words in order on an output valid/ready stream.

## Interface
- WordSize, 8, width of text/key/modulus words
- FrameLen, 12, words per frame (≥1)
- TimeoutCycles, 4096, watchdog limit per word (used only with RSA_SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  begin a frame; sampled only in IDLE
- key_in, mod_in  in  WordSize  exponent and modulus, latched on accepted start
- in_data  in  WordSize  plaintext word
- in_valid / in_ready  in / out  1  input handshake
- core_text, core_key, core_mod  out  WordSize  operands to datapath
- core_load  out  1  datapath load enable, held for whole computation
- core_running  out  1  mirrors core_load
- core_over  in  1  datapath completion flag
- core_result  in  WordSize  datapath output word
- out_data  out  WordSize  ciphertext word
- out_valid / out_ready  out / in  1  output handshake
- out_last  out  1  high with the final word of the frame
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse after the last word is accepted
- timeout_err  out  1  sticky watchdog error

## Operation
- States: IDLE, FETCH, COMPUTE, EMIT, DONE.
- IDLE: start=1 → latch key_in/mod_in, word count ← 0, clear timeout_err, go to FETCH.
- FETCH: in_ready=1. in_valid=1 registers in_data into core_text → COMPUTE.
- COMPUTE: core_load=core_running=1. core_text/key/mod stay stable. core_over is ignored in the first COMPUTE cycle; this masks a stale flag from the previous word. From the second cycle on, core_over=1 captures core_result into out_data → EMIT, and core_load drops.
- EMIT: out_valid=1. out_last=1 when count==FrameLen-1. out_data is stable until accepted. On out_ready: if last → DONE, else count+1 → FETCH.
- DONE: done=1 for one cycle → IDLE.
- start is ignored while busy. in_ready=0 outside FETCH. No input/output overlap.
- Count width is $clog2(FrameLen) with a minimum of 1. The count never wraps inside a frame.

## Timing
- Reset values: in_ready, out_valid, out_last, core_load, core_running, busy, done, timeout_err = 0. All data outputs = 0. State IDLE.
- start → in_ready: 1 cycle. Input accept → core_load high: next cycle.
- core_over high (≥2nd COMPUTE cycle) → out_valid high: next cycle.
- Per-word overhead beyond core latency: 3 cycles with zero stall.
- Reset asserted mid-frame: immediate return to IDLE. The partial frame is discarded and no done pulse is issued.
- in_valid and out_ready are ignored outside their states.

## Configuration
- RSA_SEQ_TIMEOUT_EN defined: a cycle counter runs in COMPUTE. On reaching TimeoutCycles without core_over, timeout_err←1 (sticky until next accepted start), core_load drops, the frame is aborted to IDLE, and no done pulse is issued.
- RSA_SEQ_TIMEOUT_EN undefined: no counter, timeout_err tied 0, COMPUTE waits indefinitely.

## Structure
- Shared package rsa_rfid_pkg holds the state enum, default FRAME_LEN=12 and default TIMEOUT_CYCLES.
- One sub-module: rsa_seq_watchdog (load/clear/expire counter), instantiated only under RSA_SEQ_TIMEOUT_EN.

## Test plan
- key=7, mod=33, FrameLen=2, inputs 2,4, core model latency 10 → outputs 29 then 16; out_last on 16 only; done pulse once.
- out_ready held low 20 cycles in EMIT → out_data=29 and out_valid held stable; in_ready stays 0.
- Core model holds core_over=1 from the previous word into the first COMPUTE cycle → flag ignored; correct next result captured.
- Reset low during COMPUTE of word 1 → all outputs 0 asynchronously; next start runs a clean frame from count 0.
- start pulsed during EMIT → ignored; key latch unchanged.
- RSA_SEQ_TIMEOUT_EN, TimeoutCycles=16, core_over never asserted → timeout_err=1 after 16 COMPUTE cycles, IDLE, no done; next start clears timeout_err.

Source files
------------

// File: rtl/rsa_rfid_pkg.sv
// Shared types and default sizes for the RSA frame sequencer in the RFID tag pipeline.
package rsa_rfid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_EMIT    = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_e;

    localparam int WORD_SIZE      = 8;
    localparam int FRAME_LEN      = 12;
    localparam int TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/rsa_seq_watchdog.sv
// Cycle counter that flags expiry when enable has been held for Limit cycles since the last clear.
module rsa_seq_watchdog #(
    parameter int Limit = 4096
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CntW = $clog2(Limit + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // The limit-th enabled cycle is the one in which expiry is signalled.
    assign expire_o = enable_i && (cnt_q == CntW'(Limit - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rsa_frame_sequencer.sv
// Feeds a frame of plaintext words to the RSA datapath and streams the ciphertext back out.
// Optional per-word watchdog enabled by defining RSA_SEQ_TIMEOUT_EN.
module rsa_frame_sequencer
    import rsa_rfid_pkg::*;
#(
    parameter int WordSize      = WORD_SIZE,
    parameter int FrameLen      = FRAME_LEN,
    parameter int TimeoutCycles = TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WordSize-1:0] key_in,
    input  logic [WordSize-1:0] mod_in,
    input  logic [WordSize-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [WordSize-1:0] core_text,
    output logic [WordSize-1:0] core_key,
    output logic [WordSize-1:0] core_mod,
    output logic                core_load,
    output logic                core_running,
    input  logic                core_over,
    input  logic [WordSize-1:0] core_result,
    output logic [WordSize-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic                done,
    output logic                timeout_err
);

    localparam int CountW = (FrameLen > 1) ? $clog2(FrameLen) : 1;
    localparam logic [CountW-1:0] LastCount = CountW'(FrameLen - 1);

    if (FrameLen < 1 || TimeoutCycles < 1) begin : g_badParams
    end

    seq_state_e          state_q, state_d;
    logic [CountW-1:0]   count_q, count_d;
    logic [WordSize-1:0] key_q, key_d;
    logic [WordSize-1:0] mod_q, mod_d;
    logic [WordSize-1:0] text_q, text_d;
    logic [WordSize-1:0] result_q, result_d;
    logic                armed_q, armed_d;
    logic                isLast;
    logic                capture;
    logic                expired;

    assign isLast  = (count_q == LastCount);
    // armed_q is low in the first COMPUTE cycle so a stale flag from the previous word is ignored.
    assign capture = (state_q == ST_COMPUTE) && armed_q && core_over;

`ifdef RSA_SEQ_TIMEOUT_EN
    logic timeoutErr_q;

    rsa_seq_watchdog #(
        .Limit(TimeoutCycles)
    ) u_watchdog (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clear_i (state_q != ST_COMPUTE),
        .enable_i(state_q == ST_COMPUTE),
        .expire_o(expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeoutErr_q <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            timeoutErr_q <= 1'b0;
        end else if (state_q == ST_COMPUTE && expired && !capture) begin
            timeoutErr_q <= 1'b1;
        end
    end

    assign timeout_err = timeoutErr_q;
`else
    assign expired     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        key_d    = key_q;
        mod_d    = mod_q;
        text_d   = text_q;
        result_d = result_q;
        armed_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    mod_d   = mod_in;
                    count_d = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (in_valid) begin
                    text_d  = in_data;
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                armed_d = 1'b1;
                if (capture) begin
                    result_d = core_result;
                    state_d  = ST_EMIT;
                end else if (expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (isLast) begin
                        state_d = ST_DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            key_q    <= '0;
            mod_q    <= '0;
            text_q   <= '0;
            result_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            key_q    <= key_d;
            mod_q    <= mod_d;
            text_q   <= text_d;
            result_q <= result_d;
            armed_q  <= armed_d;
        end
    end

    assign in_ready     = (state_q == ST_FETCH);
    assign core_load    = (state_q == ST_COMPUTE);
    assign core_running = core_load;
    assign core_text    = text_q;
    assign core_key     = key_q;
    assign core_mod     = mod_q;
    assign out_valid    = (state_q == ST_EMIT);
    assign out_last     = (state_q == ST_EMIT) && isLast;
    assign out_data     = result_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_rsa_frame_sequencer.sv
// Directed self-checking bench for rsa_frame_sequencer with a behavioural RSA core model.
module tb_rsa_frame_sequencer;

    localparam int WS      = 8;
    localparam int FL      = 2;
    localparam int TC      = 16;
    localparam int Latency = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [WS-1:0] key_in = '0;
    logic [WS-1:0] mod_in = '0;
    logic [WS-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WS-1:0] core_text, core_key, core_mod;
    logic          core_load, core_running;
    logic          core_over = 1'b0;
    logic [WS-1:0] core_result = '0;
    logic [WS-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          busy, done, timeout_err;

    int testsRun    = 0;
    int testsFailed = 0;
    int doneCount   = 0;
    bit staleMode   = 1'b0;
    bit coreMute    = 1'b0;
    int lat         = 0;

    rsa_frame_sequencer #(
        .WordSize(WS),
        .FrameLen(FL),
        .TimeoutCycles(TC)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .key_in(key_in), .mod_in(mod_in),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .core_text(core_text), .core_key(core_key), .core_mod(core_mod),
        .core_load(core_load), .core_running(core_running),
        .core_over(core_over), .core_result(core_result),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [WS-1:0] modExp(input logic [WS-1:0] b, input logic [WS-1:0] e,
                                             input logic [WS-1:0] n);
        int r;
        r = 1;
        for (int i = 0; i < int'(e); i++) r = (r * int'(b)) % int'(n);
        return r[WS-1:0];
    endfunction

    // Core model: result after Latency load cycles; in stale mode the flag lingers into the next word's first cycle.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_over   <= 1'b0;
            core_result <= '0;
            lat = 0;
        end else if (!core_load) begin
            lat = 0;
            if (!staleMode) core_over <= 1'b0;
        end else begin
            if (lat == 0) core_over <= 1'b0;
            lat = lat + 1;
            if (!coreMute && lat == Latency) begin
                core_over   <= 1'b1;
                core_result <= modExp(core_text, core_key, core_mod);
            end
        end
    end

    always @(posedge clk) if (done) doneCount++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic startFrame(input logic [WS-1:0] k, input logic [WS-1:0] m);
        @(negedge clk);
        start = 1'b1; key_in = k; mod_in = m;
        @(negedge clk);
        start = 1'b0; key_in = '0; mod_in = '0;
    endtask

    task automatic applyStimulus(input logic [WS-1:0] d);
        int waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("in_ready_wait", in_ready, 1);
        in_valid = 1'b1; in_data = d;
        @(negedge clk);
        in_valid = 1'b0; in_data = '0;
    endtask

    task automatic waitOutput();
        int waited = 0;
        while (!out_valid && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("out_valid_wait", out_valid, 1);
    endtask

    task automatic acceptOutput();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        bit stableOk;
        int n;

        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_core_load", core_load, 0);
        checkOutput("rst_core_running", core_running, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_timeout_err", timeout_err, 0);
        checkOutput("rst_data", {core_text, core_key, core_mod, out_data}, 0);
        reset = 1'b1;

        // Frame 1: 2,4 with key 7 mod 33, long stall on the first output
        startFrame(8'd7, 8'd33);
        checkOutput("f1_in_ready", in_ready, 1);
        checkOutput("f1_busy", busy, 1);
        applyStimulus(8'd2);
        checkOutput("f1_core_load", core_load, 1);
        checkOutput("f1_core_running", core_running, 1);
        checkOutput("f1_core_text", core_text, 2);
        checkOutput("f1_core_key", core_key, 7);
        checkOutput("f1_core_mod", core_mod, 33);
        waitOutput();
        checkOutput("f1_w0_data", out_data, 29);
        checkOutput("f1_w0_last", out_last, 0);
        stableOk = 1'b1;
        in_valid = 1'b1; in_data = 8'hAA;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== 8'd29 || in_ready !== 1'b0) stableOk = 1'b0;
        end
        in_valid = 1'b0; in_data = '0;
        checkOutput("f1_stall_stable", stableOk, 1);
        acceptOutput();
        applyStimulus(8'd4);
        checkOutput("f1_w1_core_text", core_text, 4);
        waitOutput();
        checkOutput("f1_w1_data", out_data, 16);
        checkOutput("f1_w1_last", out_last, 1);
        acceptOutput();
        checkOutput("f1_done", done, 1);
        @(negedge clk);
        checkOutput("f1_idle_busy", busy, 0);
        checkOutput("f1_done_low", done, 0);
        checkOutput("f1_done_count", doneCount, 1);

        // Frame 2: stale completion flag plus start pulse during EMIT
        staleMode = 1'b1;
        startFrame(8'd7, 8'd33);
        applyStimulus(8'd2);
        waitOutput();
        checkOutput("f2_w0_data", out_data, 29);
        start = 1'b1; key_in = 8'd3; mod_in = 8'd5;
        @(negedge clk);
        start = 1'b0; key_in = '0; mod_in = '0;
        checkOutput("f2_key_kept", core_key, 7);
        checkOutput("f2_mod_kept", core_mod, 33);
        checkOutput("f2_still_emit", out_valid, 1);
        acceptOutput();
        applyStimulus(8'd4);
        checkOutput("f2_stale_ignored", out_valid, 0);
        waitOutput();
        checkOutput("f2_w1_data", out_data, 16);
        checkOutput("f2_w1_last", out_last, 1);
        acceptOutput();
        staleMode = 1'b0;
        checkOutput("f2_done", done, 1);
        @(negedge clk);
        checkOutput("f2_done_count", doneCount, 2);

        // Frame 3: reset during COMPUTE, then a clean frame
        startFrame(8'd7, 8'd33);
        applyStimulus(8'd2);
        repeat (3) @(negedge clk);
        checkOutput("f3_computing", core_load, 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("f3_rst_core_load", core_load, 0);
        checkOutput("f3_rst_core_running", core_running, 0);
        checkOutput("f3_rst_busy", busy, 0);
        checkOutput("f3_rst_in_ready", in_ready, 0);
        checkOutput("f3_rst_out_valid", out_valid, 0);
        checkOutput("f3_rst_data", {core_text, core_key, core_mod, out_data}, 0);
        @(negedge clk);
        reset = 1'b1;
        checkOutput("f3_no_done", doneCount, 2);
        startFrame(8'd7, 8'd33);
        applyStimulus(8'd5);
        waitOutput();
        checkOutput("f3_w0_data", out_data, 14);
        checkOutput("f3_w0_last", out_last, 0);
        acceptOutput();
        applyStimulus(8'd3);
        waitOutput();
        checkOutput("f3_w1_data", out_data, 9);
        checkOutput("f3_w1_last", out_last, 1);
        acceptOutput();
        @(negedge clk);
        checkOutput("f3_done_count", doneCount, 3);

`ifdef RSA_SEQ_TIMEOUT_EN
        // Frame 4: core never completes, watchdog aborts after TC cycles
        coreMute = 1'b1;
        startFrame(8'd7, 8'd33);
        applyStimulus(8'd2);
        n = 0;
        while (core_load && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkOutput("f4_compute_cycles", n, TC);
        checkOutput("f4_timeout_err", timeout_err, 1);
        checkOutput("f4_idle", busy, 0);
        repeat (2) @(negedge clk);
        checkOutput("f4_no_done", doneCount, 3);
        checkOutput("f4_err_sticky", timeout_err, 1);
        coreMute = 1'b0;
        startFrame(8'd7, 8'd33);
        checkOutput("f4_err_cleared", timeout_err, 0);
        checkOutput("f4_restart_ready", in_ready, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
